// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Optional trap support is enabled by defining PIPE_CTRL_TRAP_EN.
package pipe_ctrl_pkg;

  // Control FSM: normal flow, multi-cycle EX stall, event latched under hold.
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StPend  = 2'd2
  } state_e;

  // Pipeline register indices.
  localparam int STG_PC   = 0;
  localparam int STG_IFID = 1;
  localparam int STG_IDEX = 2;

endpackage

// File: rtl/pipe_ctrl_stall_cnt.sv
// Loadable down-counter for multi-cycle EX stalls. Clear beats load, load beats
// count; the count holds while frozen and saturates at zero.
module pipe_ctrl_stall_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (!freeze_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: arbitrates system hold, redirects, multi-cycle EX
// stalls and load-use hazards into per-register hold/clear bits.
// Define PIPE_CTRL_TRAP_EN to add the trap redirect ports and logic.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned NSTAGE   = 5,
  parameter int unsigned EX_STAGE = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              hold_i,
  input  logic              hazard_hold_i,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              mc_start_i,
  input  logic [CNT_W-1:0]  mc_len_i,
`ifdef PIPE_CTRL_TRAP_EN
  input  logic              trap_req_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
`endif
  output logic              jump_ena_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic [NSTAGE-1:0] stage_hold_o,
  output logic [NSTAGE-1:0] stage_clr_o,
  output logic              busy_o,
  output logic              pend_o
);

  localparam int NStg  = int'(NSTAGE);
  localparam int ExIdx = int'(EX_STAGE);

  state_e            state_d, state_q;
  logic              pend_jump_d, pend_jump_q;
  logic              pend_trap_d, pend_trap_q;
  logic              pend_mc_d, pend_mc_q;
  logic [ADDR_W-1:0] pend_addr_d, pend_addr_q;
  logic [CNT_W-1:0]  pend_len_d, pend_len_q;

  logic              cnt_clr, cnt_load, cnt_freeze, cnt_zero;
  logic [CNT_W-1:0]  cnt_load_val, cnt_q;
  logic              stall_last;

  logic              jump_ena;
  logic [ADDR_W-1:0] jump_addr;
  logic [NSTAGE-1:0] stage_hold, stage_clr;
  logic [CNT_W-1:0]  mc_len_sel;

  logic              trap_live;
  logic [ADDR_W-1:0] trap_tgt;

`ifdef PIPE_CTRL_TRAP_EN
  assign trap_live = trap_req_i;
  assign trap_tgt  = trap_addr_i;
`else
  assign trap_live = 1'b0;
  assign trap_tgt  = '0;
`endif

  logic [NSTAGE-1:0] m_redir, m_trap, m_stall_hold, m_stall_clr, m_haz_hold, m_haz_clr;

  // Constant stage masks derived from the pipeline geometry.
  always_comb begin
    m_redir      = '0;
    m_trap       = '0;
    m_stall_hold = '0;
    m_stall_clr  = '0;
    m_haz_hold   = '0;
    m_haz_clr    = '0;
    for (int i = 0; i < NStg; i++) begin
      m_redir[i]      = (i >= STG_IFID) && (i <= ExIdx);
      m_trap[i]       = (i >= STG_IFID);
      m_stall_hold[i] = (i <= ExIdx);
      m_stall_clr[i]  = (i == ExIdx + 1);
      m_haz_hold[i]   = (i < ExIdx);
      m_haz_clr[i]    = (i == ExIdx);
    end
  end

  // Stall counter only runs while stalled and not under system hold.
  assign cnt_freeze = hold_i || (state_q != StStall);
  // True when this unheld stall cycle is the final one.
  assign stall_last = cnt_zero || (cnt_q == CNT_W'(1));

  // Next-state, latching and per-cycle control outputs, in priority order.
  always_comb begin
    state_d      = state_q;
    pend_jump_d  = pend_jump_q;
    pend_trap_d  = pend_trap_q;
    pend_mc_d    = pend_mc_q;
    pend_addr_d  = pend_addr_q;
    pend_len_d   = pend_len_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = mc_len_i;
    mc_len_sel   = mc_len_i;
    jump_ena     = 1'b0;
    jump_addr    = '0;
    stage_hold   = '0;
    stage_clr    = '0;

    if (hold_i) begin
      stage_hold = '1;
      // A trap replaces any latched jump; a later jump never overwrites a trap.
      if (trap_live) begin
        pend_trap_d = 1'b1;
        pend_jump_d = 1'b1;
        pend_addr_d = trap_tgt;
      end else if (ex_jump_i && !pend_trap_q) begin
        pend_jump_d = 1'b1;
        pend_addr_d = ex_jump_addr_i;
      end
      if (mc_start_i && (state_q != StStall)) begin
        pend_mc_d  = 1'b1;
        pend_len_d = mc_len_i;
      end
      if ((state_q == StRun) && (pend_jump_d || pend_mc_d)) begin
        state_d = StPend;
      end
    end else if (trap_live || pend_trap_q) begin
      // Trap: flush everything past the PC and abort any stall.
      jump_ena    = 1'b1;
      jump_addr   = pend_trap_q ? pend_addr_q : trap_tgt;
      stage_clr   = m_trap;
      pend_jump_d = 1'b0;
      pend_trap_d = 1'b0;
      pend_mc_d   = 1'b0;
      cnt_clr     = 1'b1;
      state_d     = StRun;
    end else if (pend_jump_q) begin
      // Replay of a redirect latched under hold; any live jump is dropped.
      jump_ena    = 1'b1;
      jump_addr   = pend_addr_q;
      stage_clr   = m_redir;
      pend_jump_d = 1'b0;
      pend_mc_d   = 1'b0;
      if (state_q == StPend) begin
        state_d = StRun;
      end else if ((state_q == StStall) && stall_last) begin
        state_d = StRun;
      end
    end else if (state_q == StStall) begin
      stage_hold = m_stall_hold;
      stage_clr  = m_stall_clr;
      if (stall_last) begin
        state_d = StRun;
      end
    end else if (ex_jump_i) begin
      // Live redirect; a same-cycle mc start (live or pending) is dropped.
      jump_ena  = 1'b1;
      jump_addr = ex_jump_addr_i;
      stage_clr = m_redir;
      pend_mc_d = 1'b0;
      state_d   = StRun;
    end else begin
      if (pend_mc_q || (mc_start_i && (state_q == StRun))) begin
        mc_len_sel   = pend_mc_q ? pend_len_q : mc_len_i;
        cnt_load_val = mc_len_sel;
        pend_mc_d    = 1'b0;
        if (mc_len_sel != '0) begin
          cnt_load = 1'b1;
          state_d  = StStall;
        end else begin
          state_d = StRun;
        end
      end else if (state_q == StPend) begin
        state_d = StRun;
      end
      if (hazard_hold_i && (state_q == StRun)) begin
        stage_hold = m_haz_hold;
        stage_clr  = m_haz_clr;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StRun;
      pend_jump_q <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_mc_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_jump_q <= pend_jump_d;
      pend_trap_q <= pend_trap_d;
      pend_mc_q   <= pend_mc_d;
      pend_addr_q <= pend_addr_d;
      pend_len_q  <= pend_len_d;
    end
  end

  pipe_ctrl_stall_cnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i      (clk_100MHz),
    .rst_ni     (arst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .freeze_i   (cnt_freeze),
    .cnt_o      (cnt_q),
    .zero_o     (cnt_zero)
  );

  // Outputs take their reset values for as long as reset is asserted.
  always_comb begin
    if (!arst_n) begin
      jump_ena_o   = 1'b0;
      jump_addr_o  = '0;
      stage_hold_o = '1;
      stage_clr_o  = '0;
      busy_o       = 1'b0;
      pend_o       = 1'b0;
    end else begin
      jump_ena_o   = jump_ena;
      jump_addr_o  = jump_addr;
      stage_hold_o = stage_hold;
      stage_clr_o  = stage_clr;
      busy_o       = (state_q == StStall);
      pend_o       = pend_jump_q || pend_mc_q || pend_trap_q;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expectations go through a scoreboard queue.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        hold, haz, jmp, mc;
  logic [31:0] jaddr;
  logic [3:0]  mlen;
  logic        jena;
  logic [31:0] jout;
  logic [4:0]  shold, sclr;
  logic        busy, pend;
`ifdef PIPE_CTRL_TRAP_EN
  logic        trap_req;
  logic [31:0] trap_addr;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        ena;
    logic [31:0] addr;
    logic [4:0]  hold;
    logic [4:0]  clr;
    logic        busy;
    logic        pend;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_ctrl #(
    .ADDR_W   (32),
    .NSTAGE   (5),
    .EX_STAGE (2),
    .CNT_W    (4)
  ) dut (
    .clk_100MHz     (clk),
    .arst_n         (arst_n),
    .hold_i         (hold),
    .hazard_hold_i  (haz),
    .ex_jump_i      (jmp),
    .ex_jump_addr_i (jaddr),
    .mc_start_i     (mc),
    .mc_len_i       (mlen),
`ifdef PIPE_CTRL_TRAP_EN
    .trap_req_i     (trap_req),
    .trap_addr_i    (trap_addr),
`endif
    .jump_ena_o     (jena),
    .jump_addr_o    (jout),
    .stage_hold_o   (shold),
    .stage_clr_o    (sclr),
    .busy_o         (busy),
    .pend_o         (pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic h, input logic hz, input logic j, input logic [31:0] a,
                       input logic m, input logic [3:0] l);
    hold  = h;
    haz   = hz;
    jmp   = j;
    jaddr = a;
    mc    = m;
    mlen  = l;
  endtask

  // Push the expectation for the current cycle, then pop and compare.
  task automatic expect_now(input string name, input logic e_ena, input logic [31:0] e_addr,
                            input logic [4:0] e_hold, input logic [4:0] e_clr,
                            input logic e_busy, input logic e_pend);
    exp_t e;
    e.name = name; e.ena = e_ena; e.addr = e_addr; e.hold = e_hold;
    e.clr = e_clr; e.busy = e_busy; e.pend = e_pend;
    sb.push_back(e);
    e = sb.pop_front();
    chk({e.name, ".jump_ena"}, 32'(jena), 32'(e.ena));
    if (e.ena || !arst_n) chk({e.name, ".jump_addr"}, jout, e.addr);
    chk({e.name, ".stage_hold"}, 32'(shold), 32'(e.hold));
    chk({e.name, ".stage_clr"}, 32'(sclr), 32'(e.clr));
    chk({e.name, ".busy"}, 32'(busy), 32'(e.busy));
    chk({e.name, ".pend"}, 32'(pend), 32'(e.pend));
  endtask

  task automatic step(input string name, input logic h, input logic hz, input logic j,
                      input logic [31:0] a, input logic m, input logic [3:0] l,
                      input logic e_ena, input logic [31:0] e_addr, input logic [4:0] e_hold,
                      input logic [4:0] e_clr, input logic e_busy, input logic e_pend);
    @(negedge clk);
    drive(h, hz, j, a, m, l);
    #1;
    expect_now(name, e_ena, e_addr, e_hold, e_clr, e_busy, e_pend);
  endtask

  initial begin
    arst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 4'd0);
`ifdef PIPE_CTRL_TRAP_EN
    trap_req  = 1'b0;
    trap_addr = 32'h0;
`endif
    #3;
    expect_now("reset", 0, 32'h0, 5'b11111, 5'b00000, 0, 0);
    @(negedge clk);
    arst_n = 1'b1;

    //     name         h  hz j  addr        mc len  ena addr        hold      clr       bsy pnd
    step("idle0",       0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
    step("live_jump",   0, 0, 1, 32'h100,    0, 0,   1, 32'h100,    5'b00000, 5'b00110, 0, 0);
    step("after_jump",  0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);

    step("hj_c1",       1, 0, 1, 32'h200,    0, 0,   0, 32'h0,      5'b11111, 5'b00000, 0, 0);
    step("hj_c2",       1, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b11111, 5'b00000, 0, 1);
    step("hj_c3",       1, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b11111, 5'b00000, 0, 1);
    step("hj_issue",    0, 0, 0, 32'h0,      0, 0,   1, 32'h200,    5'b00000, 5'b00110, 0, 1);
    step("hj_done",     0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);

    step("mc_start",    0, 0, 0, 32'h0,      1, 3,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
    step("mc_s1_haz",   0, 1, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("mc_s2_jmp",   0, 0, 1, 32'h900,    0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("mc_s3",       0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("mc_end",      0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);

    step("st_start",    0, 0, 0, 32'h0,      1, 3,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
    step("st_s1",       0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("st_hold",     1, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b11111, 5'b00000, 1, 0);
    step("st_s2",       0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("st_s3",       0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("st_end",      0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);

    step("hazard",      0, 1, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00011, 5'b00100, 0, 0);
    step("haz_jump",    0, 1, 1, 32'h300,    0, 0,   1, 32'h300,    5'b00000, 5'b00110, 0, 0);

    step("jmp_mc",      0, 0, 1, 32'h400,    1, 2,   1, 32'h400,    5'b00000, 5'b00110, 0, 0);
    step("jmp_mc_after",0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
    step("mc_len0",     0, 0, 0, 32'h0,      1, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
    step("mc_len0_nxt", 0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);

    step("pmc_latch",   1, 0, 0, 32'h0,      1, 2,   0, 32'h0,      5'b11111, 5'b00000, 0, 0);
    step("pmc_issue",   0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 1);
    step("pmc_s1",      0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("pmc_s2",      0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("pmc_end",     0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);

    step("pj_latch",    1, 0, 1, 32'h600,    0, 0,   0, 32'h0,      5'b11111, 5'b00000, 0, 0);
    step("pj_vs_live",  0, 0, 1, 32'h700,    0, 0,   1, 32'h600,    5'b00000, 5'b00110, 0, 1);
    step("pj_done",     0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);

    step("rs_start",    0, 0, 0, 32'h0,      1, 5,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
    step("rs_s1",       0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    step("rs_hjump",    1, 0, 1, 32'h500,    0, 0,   0, 32'h0,      5'b11111, 5'b00000, 1, 0);
    step("rs_pend",     1, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b11111, 5'b00000, 1, 1);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    expect_now("rs_reset", 0, 32'h0, 5'b11111, 5'b00000, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 4'd0);
    arst_n = 1'b1;
    #1;
    expect_now("rs_release", 0, 32'h0, 5'b00000, 5'b00000, 0, 0);
    step("rs_idle1",    0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
    step("rs_idle2",    0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);

`ifdef PIPE_CTRL_TRAP_EN
    step("tr_start",    0, 0, 0, 32'h0,      1, 3,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
    step("tr_s1",       0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00111, 5'b01000, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 4'd0);
    trap_req  = 1'b1;
    trap_addr = 32'h800;
    #1;
    expect_now("tr_issue", 1, 32'h800, 5'b00000, 5'b11110, 1, 0);
    @(negedge clk);
    trap_req = 1'b0;
    #1;
    expect_now("tr_after", 0, 32'h0, 5'b00000, 5'b00000, 0, 0);
    step("trh_jump",    1, 0, 1, 32'hA00,    0, 0,   0, 32'h0,      5'b11111, 5'b00000, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 32'h0, 0, 4'd0);
    trap_req  = 1'b1;
    trap_addr = 32'hB00;
    #1;
    expect_now("trh_trap", 0, 32'h0, 5'b11111, 5'b00000, 0, 1);
    @(negedge clk);
    trap_req = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 4'd0);
    #1;
    expect_now("trh_issue", 1, 32'hB00, 5'b00000, 5'b11110, 0, 1);
    step("trh_done",    0, 0, 0, 32'h0,      0, 0,   0, 32'h0,      5'b00000, 5'b00000, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
